rob_id_alloc: RTL and testbench

//   Allocates and reclaims reorder-buffer IDs in strict program order for two

---
 rtl/rob_id_alloc.sv | 91 +++++++++
 tb/tb_rob_id_alloc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rob_id_alloc.sv
// Hands out reorder-buffer IDs in program order to two dispatch ports and reclaims them oldest-first.
// head/tail carry an extra wrap bit so a full ring and an empty ring can be told apart.
module rob_id_alloc #(
    parameter int ID_WIDTH = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    output logic [ID_WIDTH-1:0] alloc_id_o,
    output logic                alloc_wrap_o,
    input  logic                retire_i,
    output logic [ID_WIDTH-1:0] retire_id_o,
    input  logic                flush_i,
    output logic [ID_WIDTH:0]   count_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam logic [ID_WIDTH:0] FULL_COUNT = {1'b1, {ID_WIDTH{1'b0}}};
    localparam logic [ID_WIDTH:0] PTR_ONE    = {{ID_WIDTH{1'b0}}, 1'b1};

    logic [ID_WIDTH:0] head_q, head_d;
    logic [ID_WIDTH:0] tail_q, tail_d;
    logic              rr_pri_q, rr_pri_d;
    logic              can_alloc;
    logic              grant0, grant1;
    logic              retire_fire;

    assign count_o      = head_q - tail_q;
    assign full_o       = (count_o == FULL_COUNT);
    assign empty_o      = (count_o == '0);
    assign alloc_id_o   = head_q[ID_WIDTH-1:0];
    assign alloc_wrap_o = head_q[ID_WIDTH];
    assign retire_id_o  = tail_q[ID_WIDTH-1:0];

    assign can_alloc    = !full_o && !flush_i;
    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    always_comb begin
        grant0      = 1'b0;
        grant1      = 1'b0;
        retire_fire = retire_i && !empty_o;
        head_d      = head_q;
        tail_d      = tail_q;
        rr_pri_d    = rr_pri_q;

        if (can_alloc) begin
            if (req0_valid_i && req1_valid_i) begin
                grant0 = !rr_pri_q;
                grant1 = rr_pri_q;
            end else begin
                grant0 = req0_valid_i;
                grant1 = req1_valid_i;
            end
        end

        if (grant0) begin
            rr_pri_d = 1'b1;
        end else if (grant1) begin
            rr_pri_d = 1'b0;
        end

        if (retire_fire) begin
            tail_d = tail_q + PTR_ONE;
        end

        if (flush_i) begin
            // Discard by collapsing tail onto head: ring empties, the ID sequence keeps counting up.
            tail_d = head_q;
        end else if (grant0 || grant1) begin
            head_d = head_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            rr_pri_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            rr_pri_q <= rr_pri_d;
        end
    end

endmodule

// File: tb/tb_rob_id_alloc.sv
// Bench for rob_id_alloc: directed scenarios plus a random run against a queue-based model of in-flight IDs.
module tb_rob_id_alloc;

    localparam int W     = 3;
    localparam int DEPTH = 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic         retire_i = 1'b0, flush_i = 1'b0;
    logic         req0_ready_o, req1_ready_o, alloc_wrap_o, full_o, empty_o;
    logic [W-1:0] alloc_id_o, retire_id_o;
    logic [W:0]   count_o;

    rob_id_alloc #(.ID_WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .alloc_id_o(alloc_id_o), .alloc_wrap_o(alloc_wrap_o),
        .retire_i(retire_i), .retire_id_o(retire_id_o),
        .flush_i(flush_i), .count_o(count_o),
        .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Model: every allocation gets the next sequence number; in-flight ones sit in a FIFO.
    int next_seq;
    int inflight[$];
    bit favour1;
    bit exp_g0, exp_g1, exp_full, exp_empty, exp_wrap;
    int exp_cnt, exp_id, exp_ret;

    task automatic model_reset();
        inflight.delete();
        next_seq = 0;
        favour1  = 1'b0;
    endtask

    task automatic drive(input bit r0, input bit r1, input bit ret, input bit fl);
        bit can;
        @(negedge clk_i);
        req0_valid_i = r0; req1_valid_i = r1; retire_i = ret; flush_i = fl;
        #1;
        exp_cnt   = inflight.size();
        exp_full  = (exp_cnt == DEPTH);
        exp_empty = (exp_cnt == 0);
        exp_id    = next_seq % DEPTH;
        exp_wrap  = ((next_seq / DEPTH) % 2) == 1;
        exp_ret   = exp_empty ? (next_seq % DEPTH) : (inflight[0] % DEPTH);
        can       = !exp_full && !fl;
        exp_g0    = can && r0 && (!r1 || !favour1);
        exp_g1    = can && r1 && (!r0 || favour1);
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (retire_i && !exp_empty) void'(inflight.pop_front());
        if (exp_g0 || exp_g1) begin
            inflight.push_back(next_seq);
            next_seq++;
            favour1 = exp_g0;
        end
        if (flush_i) inflight.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        req0_valid_i = 0; req1_valid_i = 0; retire_i = 0; flush_i = 0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (count_o !== 0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count_o); end
        vectors++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin miscompares++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", empty_o, full_o); end
        vectors++; if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b%b want 00", req0_ready_o, req1_ready_o); end
        vectors++; if (alloc_id_o !== 0 || alloc_wrap_o !== 1'b0 || retire_id_o !== 0) begin miscompares++; $display("FAIL reset_ids got id=%0d wrap=%b ret=%0d want 0/0/0", alloc_id_o, alloc_wrap_o, retire_id_o); end
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_port0_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 0);
            vectors++; if (req0_ready_o !== 1'b1 || alloc_id_o !== W'(i)) begin miscompares++; $display("FAIL fill_grant[%0d] got rdy=%b id=%0d want 1/%0d", i, req0_ready_o, alloc_id_o, i); end
            tick();
        end
        drive(1, 0, 0, 0);
        vectors++; if (full_o !== 1'b1 || req0_ready_o !== 1'b0 || count_o !== 4'(DEPTH)) begin miscompares++; $display("FAIL fill_full got full=%b rdy=%b cnt=%0d want 1/0/8", full_o, req0_ready_o, count_o); end
        tick();
    endtask

    task automatic test_full_retire();
        drive(1, 0, 1, 0);
        vectors++; if (req0_ready_o !== 1'b0 || retire_id_o !== 0) begin miscompares++; $display("FAIL full_retire_nobypass got rdy=%b ret=%0d want 0/0", req0_ready_o, retire_id_o); end
        tick();
        drive(1, 0, 0, 0);
        vectors++; if (count_o !== 7 || req0_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_retire_after got cnt=%0d rdy=%b want 7/1", count_o, req0_ready_o); end
        vectors++; if (alloc_id_o !== 0 || alloc_wrap_o !== 1'b1) begin miscompares++; $display("FAIL full_retire_wrapid got id=%0d wrap=%b want 0/1", alloc_id_o, alloc_wrap_o); end
        tick();
        for (int i = 0; i < DEPTH; i++) begin drive(0, 0, 1, 0); tick(); end
    endtask

    task automatic test_retire_empty();
        drive(0, 0, 1, 0);
        vectors++; if (count_o !== 0 || retire_id_o !== 1) begin miscompares++; $display("FAIL retire_empty_pre got cnt=%0d ret=%0d want 0/1", count_o, retire_id_o); end
        tick();
        drive(0, 0, 0, 0);
        vectors++; if (count_o !== 0 || retire_id_o !== 1 || empty_o !== 1'b1) begin miscompares++; $display("FAIL retire_empty_post got cnt=%0d ret=%0d empty=%b want 0/1/1", count_o, retire_id_o, empty_o); end
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin drive(0, 1, 0, 0); tick(); end
        for (int i = 0; i < DEPTH; i++) begin drive(0, 0, 1, 0); tick(); end
        drive(0, 1, 0, 0);
        vectors++; if (alloc_id_o !== 0 || alloc_wrap_o !== 1'b1 || req1_ready_o !== 1'b1) begin miscompares++; $display("FAIL wrap got id=%0d wrap=%b rdy1=%b want 0/1/1", alloc_id_o, alloc_wrap_o, req1_ready_o); end
        tick();
    endtask

    task automatic test_alternate();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0);
            vectors++; if (req0_ready_o !== (i % 2 == 0) || req1_ready_o !== (i % 2 == 1) || alloc_id_o !== W'(i)) begin miscompares++; $display("FAIL alternate[%0d] got r0=%b r1=%b id=%0d want %b/%b/%0d", i, req0_ready_o, req1_ready_o, alloc_id_o, i % 2 == 0, i % 2 == 1, i); end
            tick();
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0); tick(); end
        drive(1, 1, 0, 1);
        vectors++; if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0 || count_o !== 5) begin miscompares++; $display("FAIL flush_ready got r0=%b r1=%b cnt=%0d want 0/0/5", req0_ready_o, req1_ready_o, count_o); end
        tick();
        drive(1, 1, 0, 0);
        vectors++; if (empty_o !== 1'b1 || alloc_id_o !== 5 || count_o !== 0) begin miscompares++; $display("FAIL flush_after got empty=%b id=%0d cnt=%0d want 1/5/0", empty_o, alloc_id_o, count_o); end
        vectors++; if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_rrpri got r0=%b r1=%b want 0/1", req0_ready_o, req1_ready_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0); tick();
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        vectors++; if (count_o !== 0 || alloc_id_o !== 0 || empty_o !== 1'b1 || retire_id_o !== 0) begin miscompares++; $display("FAIL reset_mid got cnt=%0d id=%0d empty=%b ret=%0d want 0/0/1/0", count_o, alloc_id_o, empty_o, retire_id_o); end
        req0_valid_i = 0; req1_valid_i = 0; retire_i = 0; flush_i = 0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_random();
        bit p0, p1, ret, fl;
        p0 = 0; p1 = 0;
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            if (!p0) p0 = ($urandom_range(0, 2) != 0);
            if (!p1) p1 = ($urandom_range(0, 2) != 0);
            ret = ($urandom_range(0, 9) < 4);
            fl  = ($urandom_range(0, 24) == 0);
            drive(p0, p1, ret, fl);
            vectors++; if (req0_ready_o !== exp_g0 || req1_ready_o !== exp_g1) begin miscompares++; $display("FAIL rand_grant[%0d] got %b%b want %b%b", i, req0_ready_o, req1_ready_o, exp_g0, exp_g1); end
            vectors++; if (count_o !== 4'(exp_cnt) || full_o !== exp_full || empty_o !== exp_empty) begin miscompares++; $display("FAIL rand_occ[%0d] got cnt=%0d f=%b e=%b want %0d/%b/%b", i, count_o, full_o, empty_o, exp_cnt, exp_full, exp_empty); end
            vectors++; if (alloc_id_o !== W'(exp_id) || alloc_wrap_o !== exp_wrap) begin miscompares++; $display("FAIL rand_alloc[%0d] got id=%0d w=%b want %0d/%b", i, alloc_id_o, alloc_wrap_o, exp_id, exp_wrap); end
            vectors++; if (retire_id_o !== W'(exp_ret)) begin miscompares++; $display("FAIL rand_retire[%0d] got %0d want %0d", i, retire_id_o, exp_ret); end
            if (exp_g0) p0 = 0;
            if (exp_g1) p1 = 0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_port0_fill();
        test_full_retire();
        test_retire_empty();
        test_wrap();
        test_alternate();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
